// File: rtl/digitallock_hex_pkg.sv
// Shared definitions for the digital lock seven-segment controller.
// Holds the Avalon register addresses, field widths, the active-high
// gfedcba segment table and a lookup helper used by the digit decoder.
package digitallock_hex_pkg;

  localparam int DIGIT_W    = 4;
  localparam int SEG_W      = 7;
  localparam int REG_W      = 32;
  localparam int MAX_DIGITS = 8;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_EN     = 3'd1;
  localparam logic [2:0] ADDR_BLINK  = 3'd2;
  localparam logic [2:0] ADDR_DIV    = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;

  // Entry n sits at bits [7n+6:7n]; entry 0 is the least significant.
  localparam logic [16*SEG_W-1:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // All segments off, expressed in active-high form.
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  function automatic logic [SEG_W-1:0] seg_pattern(input logic [DIGIT_W-1:0] value);
    return SEG_TABLE[int'(value)*SEG_W +: SEG_W];
  endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational nibble to seven-segment decoder.
// Ports:
//   nibble : 4-bit digit value 0..F
//   seg    : gfedcba pattern, inverted when ACTIVE_LOW is set
module hex_seg_decode
  import digitallock_hex_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [DIGIT_W-1:0] nibble,
  output logic [SEG_W-1:0]   seg
);

  logic [SEG_W-1:0] seg_high;

  assign seg_high = seg_pattern(nibble);
  assign seg      = ACTIVE_LOW ? ~seg_high : seg_high;

endmodule

// File: rtl/digitallock_hex_ctrl.sv
// Avalon-MM slave driving NUM_DIGITS seven-segment displays with per-digit
// enable, per-digit blink with a programmable half-period, and selectable
// output polarity.
// Ports:
//   clk, reset            : system clock, asynchronous active-high reset
//   address, chipselect,
//   write_n, writedata    : Avalon write port (zero wait states)
//   readdata              : combinational read mux, zero-extended
//   out_port              : registered segments, digit k at [7k+6:7k]
//   blink_phase           : current blink phase, 1 = blinking digits visible
module digitallock_hex_ctrl
  import digitallock_hex_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_W      = 26,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [2:0]                  address,
  input  logic                        chipselect,
  input  logic                        write_n,
  input  logic [REG_W-1:0]            writedata,
  output logic [REG_W-1:0]            readdata,
  output logic [SEG_W*NUM_DIGITS-1:0] out_port,
  output logic                        blink_phase
);

  localparam int DATA_W = DIGIT_W * NUM_DIGITS;
  localparam int OUT_W  = SEG_W * NUM_DIGITS;

  localparam logic [SEG_W-1:0] SEG_OFF  = ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;
  localparam logic [SEG_W-1:0] SEG_ZERO = ACTIVE_LOW ? ~SEG_TABLE[SEG_W-1:0]
                                                     : SEG_TABLE[SEG_W-1:0];
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [DATA_W-1:0]     data_q,  data_d;
  logic [NUM_DIGITS-1:0] en_q,    en_d;
  logic [NUM_DIGITS-1:0] blink_q, blink_d;
  logic [DIV_W-1:0]      div_q,   div_d;
  logic [DIV_W-1:0]      cnt_q,   cnt_d;
  logic                  phase_q, phase_d;
  logic [OUT_W-1:0]      out_q,   out_d;

  logic                  wr_en;
  logic                  wr_div;
  logic [SEG_W-1:0]      seg_dec [NUM_DIGITS];

  // Bits of writedata above a register's width are dropped on purpose.
  logic                  unused_wdata;
  assign unused_wdata = ^writedata;

  assign wr_en  = chipselect & ~write_n;
  assign wr_div = wr_en & (address == ADDR_DIV);

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dec
    hex_seg_decode #(
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_dec (
      .nibble(data_q[k*DIGIT_W +: DIGIT_W]),
      .seg   (seg_dec[k])
    );
  end

  // Register file write decode.
  always_comb begin
    data_d  = data_q;
    en_d    = en_q;
    blink_d = blink_q;
    div_d   = div_q;
    if (wr_en) begin
      unique case (address)
        ADDR_DATA:  data_d  = writedata[DATA_W-1:0];
        ADDR_EN:    en_d    = writedata[NUM_DIGITS-1:0];
        ADDR_BLINK: blink_d = writedata[NUM_DIGITS-1:0];
        ADDR_DIV:   div_d   = writedata[DIV_W-1:0];
        default: ;
      endcase
    end
  end

  // Blink divider. A DIV write restarts the phase and beats a wrap on the
  // same edge; DIV=0 parks the divider with digits steadily visible.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (wr_div || (div_q == '0)) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == div_q - DIV_ONE) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + DIV_ONE;
    end
  end

  // Segment output is computed from the current register state, so every
  // register change shows up on out_port one clock later.
  always_comb begin
    out_d = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (en_q[k] && (!blink_q[k] || phase_q)) begin
        out_d[k*SEG_W +: SEG_W] = seg_dec[k];
      end else begin
        out_d[k*SEG_W +: SEG_W] = SEG_OFF;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      en_q    <= '1;
      blink_q <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b1;
      out_q   <= {NUM_DIGITS{SEG_ZERO}};
    end else begin
      data_q  <= data_d;
      en_q    <= en_d;
      blink_q <= blink_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      out_q   <= out_d;
    end
  end

  // Read mux, zero-extended; unmapped addresses read 0.
  always_comb begin
    readdata = '0;
    unique case (address)
      ADDR_DATA:   readdata[DATA_W-1:0]     = data_q;
      ADDR_EN:     readdata[NUM_DIGITS-1:0] = en_q;
      ADDR_BLINK:  readdata[NUM_DIGITS-1:0] = blink_q;
      ADDR_DIV:    readdata[DIV_W-1:0]      = div_q;
      ADDR_STATUS: readdata[0]              = phase_q;
      default: ;
    endcase
  end

  assign out_port    = out_q;
  assign blink_phase = phase_q;

endmodule

// File: tb/tb_digitallock_hex_ctrl.sv
// Self-checking bench for digitallock_hex_ctrl (4 digits, active-low).
// Expected values come from a cycle-count model: the blink phase is derived
// arithmetically from the number of edges since the last DIV write.
module tb_digitallock_hex_ctrl;

  localparam int ND = 4;

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [27:0] out_port;
  logic        blink_phase;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [15:0] m_data;
  logic [3:0]  m_en;
  logic [3:0]  m_blink;
  logic [25:0] m_div;
  int          cyc;
  int          div_t0;
  logic [27:0] exp_out;

  logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  digitallock_hex_ctrl #(
    .NUM_DIGITS(ND),
    .DIV_W     (26),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .blink_phase(blink_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Blink phase after edge number cyc: toggles every DIV edges since the DIV write.
  function automatic logic model_phase();
    if (m_div == 26'd0) return 1'b1;
    return (((cyc - div_t0) / int'(m_div)) % 2) == 0;
  endfunction

  function automatic logic [27:0] exp_segs(input logic [15:0] d, input logic [3:0] en,
                                           input logic [3:0] bl, input logic ph);
    logic [27:0] r;
    r = '0;
    for (int k = 0; k < ND; k++) begin
      if (en[k] && (!bl[k] || ph)) r[k*7 +: 7] = ~seg_tbl[d[k*4 +: 4]];
      else                         r[k*7 +: 7] = 7'h7F;
    end
    return r;
  endfunction

  function automatic logic [31:0] rd_model(input logic [2:0] a);
    case (a)
      3'd0:    return {16'd0, m_data};
      3'd1:    return {28'd0, m_en};
      3'd2:    return {28'd0, m_blink};
      3'd3:    return {6'd0, m_div};
      3'd4:    return {31'd0, model_phase()};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_data  = '0;
    m_en    = 4'hF;
    m_blink = '0;
    m_div   = '0;
    cyc     = 0;
    div_t0  = 0;
    exp_out = 28'h8102040;
  endtask

  // One clock: optionally write, then advance the model past the edge.
  task automatic tick(input logic wr, input logic [2:0] addr, input logic [31:0] wd);
    chipselect = wr;
    write_n    = !wr;
    address    = addr;
    writedata  = wd;
    @(posedge clk);
    exp_out = exp_segs(m_data, m_en, m_blink, model_phase());
    cyc++;
    if (wr) begin
      case (addr)
        3'd0: m_data  = wd[15:0];
        3'd1: m_en    = wd[3:0];
        3'd2: m_blink = wd[3:0];
        3'd3: begin m_div = wd[25:0]; div_t0 = cyc; end
        default: ;
      endcase
    end
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = '0;
    model_reset();
    #12;
    checks++;
    if (out_port !== 28'h8102040) begin
      errors++; $display("[TB] FAIL reset_out got %h exp %h", out_port, 28'h8102040);
    end
    checks++;
    if (blink_phase !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_phase got %b exp 1", blink_phase);
    end
    reset = 1'b0;
    for (int a = 0; a < 5; a++) begin
      address = 3'(a); #1;
      checks++;
      if (readdata !== rd_model(3'(a))) begin
        errors++; $display("[TB] FAIL reset_rd%0d got %h exp %h", a, readdata, rd_model(3'(a)));
      end
    end
  endtask

  task automatic test_decode();
    tick(1'b1, 3'd0, 32'h0000_1A2F);
    checks++;
    if (out_port !== 28'h8102040) begin
      errors++; $display("[TB] FAIL decode_latency got %h exp %h", out_port, 28'h8102040);
    end
    tick(1'b0, 3'd0, 32'd0);
    checks++;
    if (out_port !== {7'h79, 7'h08, 7'h24, 7'h0E}) begin
      errors++; $display("[TB] FAIL decode_out got %h exp %h", out_port, {7'h79, 7'h08, 7'h24, 7'h0E});
    end
    address = 3'd0; #1;
    checks++;
    if (readdata !== 32'h1A2F) begin
      errors++; $display("[TB] FAIL decode_rd got %h exp %h", readdata, 32'h1A2F);
    end
  endtask

  task automatic test_enable();
    tick(1'b1, 3'd1, 32'h5);
    tick(1'b0, 3'd0, 32'd0);
    checks++;
    if (out_port !== {7'h7F, 7'h08, 7'h7F, 7'h0E}) begin
      errors++; $display("[TB] FAIL en_out got %h exp %h", out_port, {7'h7F, 7'h08, 7'h7F, 7'h0E});
    end
    address = 3'd1; #1;
    checks++;
    if (readdata !== 32'h5) begin
      errors++; $display("[TB] FAIL en_rd got %h exp 5", readdata);
    end
    tick(1'b1, 3'd1, 32'hFFFF_FFFF);
    address = 3'd1; #1;
    checks++;
    if (readdata !== 32'hF) begin
      errors++; $display("[TB] FAIL en_rd_mask got %h exp f", readdata);
    end
  endtask

  task automatic test_blink();
    tick(1'b1, 3'd3, 32'd3);
    tick(1'b1, 3'd2, 32'h1);
    for (int i = 0; i < 14; i++) begin
      tick(1'b0, 3'd0, 32'd0);
      checks++;
      if (blink_phase !== model_phase()) begin
        errors++; $display("[TB] FAIL blink_phase[%0d] got %b exp %b", i, blink_phase, model_phase());
      end
      checks++;
      if (out_port !== exp_out) begin
        errors++; $display("[TB] FAIL blink_out[%0d] got %h exp %h", i, out_port, exp_out);
      end
      checks++;
      if (out_port[27:7] !== {7'h79, 7'h08, 7'h24}) begin
        errors++; $display("[TB] FAIL blink_steady[%0d] got %h exp %h", i, out_port[27:7], {7'h79, 7'h08, 7'h24});
      end
    end
  endtask

  task automatic test_div_rewrite();
    // Advance to the edge on which the divider would wrap.
    for (int i = 0; i < 10 && ((cyc + 1 - div_t0) % int'(m_div)) != 0; i++)
      tick(1'b0, 3'd0, 32'd0);
    tick(1'b1, 3'd3, 32'd5);
    checks++;
    if (blink_phase !== 1'b1) begin
      errors++; $display("[TB] FAIL div_rewrite_phase got %b exp 1", blink_phase);
    end
    for (int i = 1; i <= 6; i++) begin
      tick(1'b0, 3'd0, 32'd0);
      checks++;
      if (blink_phase !== (i < 5)) begin
        errors++; $display("[TB] FAIL div_rewrite_t%0d got %b exp %b", i, blink_phase, (i < 5));
      end
      checks++;
      if (out_port !== exp_out) begin
        errors++; $display("[TB] FAIL div_rewrite_out%0d got %h exp %h", i, out_port, exp_out);
      end
    end
    tick(1'b1, 3'd3, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 3'd0, 32'd0);
      checks++;
      if (blink_phase !== 1'b1 || out_port[6:0] !== 7'h0E) begin
        errors++; $display("[TB] FAIL div0_steady[%0d] got %b/%h exp 1/0e", i, blink_phase, out_port[6:0]);
      end
    end
  endtask

  task automatic test_reserved();
    for (int a = 5; a < 8; a++) begin
      tick(1'b1, 3'(a), $urandom);
      address = 3'(a); #1;
      checks++;
      if (readdata !== 32'd0) begin
        errors++; $display("[TB] FAIL reserved_rd%0d got %h exp 0", a, readdata);
      end
    end
    for (int a = 0; a < 4; a++) begin
      address = 3'(a); #1;
      checks++;
      if (readdata !== rd_model(3'(a))) begin
        errors++; $display("[TB] FAIL reserved_keep%0d got %h exp %h", a, readdata, rd_model(3'(a)));
      end
    end
  endtask

  task automatic test_back_to_back();
    tick(1'b1, 3'd0, 32'hDEAD_9C47);
    tick(1'b1, 3'd1, 32'h0000_000B);
    tick(1'b1, 3'd2, 32'h0000_0006);
    tick(1'b1, 3'd3, 32'hFC00_0002);
    for (int a = 0; a < 5; a++) begin
      address = 3'(a); #1;
      checks++;
      if (readdata !== rd_model(3'(a))) begin
        errors++; $display("[TB] FAIL b2b_rd%0d got %h exp %h", a, readdata, rd_model(3'(a)));
      end
    end
    tick(1'b0, 3'd0, 32'd0);
    checks++;
    if (out_port !== exp_out) begin
      errors++; $display("[TB] FAIL b2b_out got %h exp %h", out_port, exp_out);
    end
  endtask

  task automatic test_random();
    logic [2:0]  a;
    logic [31:0] wd;
    logic        wr;
    for (int i = 0; i < 300; i++) begin
      wr = ($urandom_range(0, 9) < 4);
      a  = 3'($urandom_range(0, 7));
      wd = $urandom;
      if (a == 3'd3) wd = {wd[31:26], 23'd0, 3'($urandom_range(0, 4))};
      tick(wr, a, wd);
      checks++;
      if (out_port !== exp_out) begin
        errors++; $display("[TB] FAIL rand_out[%0d] got %h exp %h", i, out_port, exp_out);
      end
      checks++;
      if (blink_phase !== model_phase()) begin
        errors++; $display("[TB] FAIL rand_phase[%0d] got %b exp %b", i, blink_phase, model_phase());
      end
      a = 3'($urandom_range(0, 7));
      address = a; #1;
      checks++;
      if (readdata !== rd_model(a)) begin
        errors++; $display("[TB] FAIL rand_rd[%0d] a=%0d got %h exp %h", i, a, readdata, rd_model(a));
      end
    end
  endtask

  task automatic test_mid_reset();
    tick(1'b1, 3'd2, 32'hF);
    tick(1'b1, 3'd3, 32'd2);
    for (int i = 0; i < 5; i++) tick(1'b0, 3'd0, 32'd0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (out_port !== 28'h8102040) begin
      errors++; $display("[TB] FAIL midrst_out got %h exp %h", out_port, 28'h8102040);
    end
    checks++;
    if (blink_phase !== 1'b1) begin
      errors++; $display("[TB] FAIL midrst_phase got %b exp 1", blink_phase);
    end
    for (int a = 0; a < 4; a++) begin
      address = 3'(a); #1;
      checks++;
      if (readdata !== rd_model(3'(a))) begin
        errors++; $display("[TB] FAIL midrst_rd%0d got %h exp %h", a, readdata, rd_model(3'(a)));
      end
    end
    reset = 1'b0;
    tick(1'b1, 3'd3, 32'd3);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 3'd0, 32'd0);
      checks++;
      if (blink_phase !== model_phase()) begin
        errors++; $display("[TB] FAIL postrst_phase[%0d] got %b exp %b", i, blink_phase, model_phase());
      end
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_enable();
    test_blink();
    test_div_rewrite();
    test_reserved();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout exp completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/digitallock_hex_ctrl.md
Name: digitallock_hex_ctrl

Overview:
Parametrised Avalon-MM slave that drives NUM_DIGITS seven-segment displays for the digital lock UI. It is the successor of the plain 28-bit HEX output register. Software writes 4-bit digit values, which are decoded to segment patterns in hardware. Adds per-digit enable, per-digit blink with a programmable period, and selectable output polarity.

Parameters:
NUM_DIGITS, 4, number of digits driven (legal range 1..8).
DIV_W, 26, width of the blink half-period divider register and counter.
ACTIVE_LOW, 1, 1 means a lit segment drives 0 (DE-series boards); 0 means a lit segment drives 1.

Ports:
clk  in  1  system clock; every register is in this domain.
reset  in  1  asynchronous, active-high reset.
address  in  3  Avalon word address.
chipselect  in  1  Avalon chip select.
write_n  in  1  Avalon write strobe, active-low.
writedata  in  32  Avalon write data.
readdata  out  32  Avalon read data; combinational from address; zero-extended.
out_port  out  7*NUM_DIGITS  segment outputs. Digit k occupies bits [7k+6:7k], bit order gfedcba (bit 0 = a).
blink_phase  out  1  current blink phase (1 = visible); for debug and LEDs.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Write occurs when chipselect=1 and write_n=0, on the rising edge of clk. Reads have no side effects.
- Register map, one 32-bit word each:
  - 0 DATA: 4*NUM_DIGITS bits; nibble k is the value of digit k.
  - 1 EN: NUM_DIGITS bits; 1 = digit shown.
  - 2 BLINK: NUM_DIGITS bits; 1 = digit blinks.
  - 3 DIV: DIV_W bits; blink half-period in clocks.
  - 4 STATUS: read-only; bit0 = blink_phase.
  - 5..7: writes ignored, reads return 0.
- Write-data bits above a register's width are ignored. Those bits read back as 0.
- Reset values:
  - DATA=0, EN=all ones, BLINK=0, DIV=0.
  - Counter=0, blink_phase=1.
  - out_port = decoded "0" on every digit (registered reset value equal to the decode of 0).
  - readdata follows the registers.
- Decode table (active-high gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, B=7C, C=39, D=5E, E=79, F=71
  - When ACTIVE_LOW=1, each pattern is inverted.
- A digit is visible when EN[k]=1 and (BLINK[k]=0 or blink_phase=1).
  - A non-visible digit drives blank: all segments off (7'h7F when active-low, 7'h00 when active-high).
- Blink divider:
  - If DIV=0: counter is held at 0 and blink_phase is held at 1 (blinking disabled, blinking digits shown steadily).
  - Else the counter increments each clock. When counter==DIV-1, it wraps to 0 and blink_phase toggles.
  - So blink_phase toggles every DIV clocks, giving a full period of 2*DIV.
- Any write to DIV, in the same edge that updates DIV:
  - clears the counter to 0;
  - sets blink_phase=1.
  - This takes priority over a toggle that would occur on that edge.
- out_port is registered, one cycle after register state.
  - A write at edge N updates the register at N.
  - out_port reflects the new value at edge N+1.
  - A blink_phase toggle at edge N appears on out_port at N+1.
- Reset asserted mid-blink: everything returns immediately (asynchronously) to the reset values. The counter restarts from 0 after reset is released.
- Back-to-back writes to different registers on consecutive cycles are all honoured. No wait states; read latency is 0.

Decomposition:
- Package digitallock_hex_pkg holds:
  - the address constants (ADDR_DATA..ADDR_STATUS);
  - the 16-entry active-high segment table;
  - the SEG_BLANK constant;
  - the register field widths.
- One sub-module: hex_seg_decode. It is a combinational nibble-to-7-segment decoder with an ACTIVE_LOW parameter, instantiated NUM_DIGITS times via generate.
- The divider, register file and output register stay in the top module.

Test Plan:
- Reset, then NUM_DIGITS=4, ACTIVE_LOW=1, no writes -> out_port=28'h8102040 (four "0" patterns 7'h40). Readback: EN=0xF, DATA=0, DIV=0, STATUS=1.
- Write DATA=0x0000_1A2F -> one cycle later, digits 3..0 show 1,A,2,F = 7'h79,08,24,0E. Readback of DATA=0x1A2F.
- Write EN=0x5 -> digits 1 and 3 show 7'h7F. Readback of EN=0x5. Write EN=0xFFFF_FFFF -> readback 0xF.
- Write DIV=3, BLINK=0x1 -> blink_phase toggles every 3 clocks. Digit 0 alternates between its decoded pattern and 7'h7F, one cycle behind the phase. Digits 1..3 stay steady.
- Rewrite DIV=5 on the cycle when the counter would wrap -> blink_phase=1, counter=0, next toggle 5 clocks later. Write DIV=0 -> digit 0 is steadily visible.
- Assert reset mid-blink, between clock edges -> out_port, blink_phase and the registers take reset values immediately. Writes to addresses 5..7 have no effect and read back 0.
